// File: rtl/quadra_ybuf_pkg.sv
// Shared quadra types and constants; quadra_top and quadra_ybuf agree on latency through QUADRA_LAT.
package quadra_ybuf_pkg;

  localparam int unsigned X_W        = 16;
  localparam int unsigned Y_W        = 24;
  localparam int unsigned QUADRA_LAT = 3;
  localparam int unsigned YBUF_DEPTH = 8;
  localparam int unsigned YBUF_LVL_W = $clog2(YBUF_DEPTH + 1);

  typedef logic                  ck_t;
  typedef logic                  rs_t;
  typedef logic                  dv_t;
  typedef logic [X_W-1:0]        x_t;
  typedef logic [Y_W-1:0]        y_t;
  typedef logic [YBUF_LVL_W-1:0] ybuf_lvl_t;

endpackage

// File: rtl/quadra_ybuf_mem.sv
// DEPTH x Y_W result storage for quadra_ybuf: one write port, asynchronous read, no reset.
module quadra_ybuf_mem
  import quadra_ybuf_pkg::*;
#(
  parameter int unsigned DEPTH = YBUF_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  y_t            wdata_i,
  input  logic [AW-1:0] raddr_i,
  output y_t            rdata_o
);

  y_t mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/quadra_ybuf.sv
// Output FIFO and credit stage behind quadra_top: buffers y/y_dv, tracks in-flight samples, drives x_ok.
// Optional QUADRA_YBUF_WMARK_EN adds a peak-occupancy output, wmark.
module quadra_ybuf
  import quadra_ybuf_pkg::*;
#(
  parameter int unsigned DEPTH = YBUF_DEPTH,
  parameter int unsigned LAT   = QUADRA_LAT,
  parameter int unsigned LVL_W = $clog2(DEPTH + 1)
) (
  input  ck_t              clk,
  input  rs_t              rst_b,
  input  dv_t              x_dv,
  output logic             x_ok,
  input  y_t               y,
  input  dv_t              y_dv,
  output y_t               m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [LVL_W-1:0] level,
`ifdef QUADRA_YBUF_WMARK_EN
  output logic [LVL_W-1:0] wmark,
`endif
  output logic             ovf,
  input  logic             ovf_clr
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned IF_W  = LVL_W + 2;
  localparam int unsigned SUM_W = IF_W + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [IF_W-1:0]  inflight_q, inflight_d;
  logic             ovf_q, ovf_d;
  logic             full, push, pop, ovf_set;
  logic [SUM_W-1:0] credit_used;

  quadra_ybuf_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (y),
    .raddr_i (rd_ptr_q),
    .rdata_o (m_data)
  );

  always_comb begin
    full    = (level_q == LVL_W'(DEPTH));
    m_valid = (level_q != '0);
    pop     = m_valid & m_ready;
    // A pop frees the slot in the same cycle, so a full FIFO can still accept.
    push    = y_dv & (~full | pop);
    ovf_set = y_dv & full & ~pop;
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    inflight_d = inflight_q;
    unique case ({x_dv, y_dv})
      2'b10:   inflight_d = inflight_q + IF_W'(1);
      // A result with nothing in flight is an upstream error; hold at zero.
      2'b01:   inflight_d = (inflight_q == '0) ? '0 : inflight_q - IF_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // Credit is derived from registers only, so x_dv never loops back into x_ok.
  always_comb begin
    credit_used = SUM_W'(level_q) + SUM_W'(inflight_q);
    x_ok        = (credit_used < SUM_W'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      inflight_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      inflight_q <= inflight_d;
      ovf_q      <= ovf_d;
    end
  end

  assign level = level_q;
  assign ovf   = ovf_q;

`ifdef QUADRA_YBUF_WMARK_EN
  logic [LVL_W-1:0] wmark_q, wmark_d;

  always_comb begin
    wmark_d = wmark_q;
    if (ovf_clr) begin
      wmark_d = level_q;
    end else if (level_q > wmark_q) begin
      wmark_d = level_q;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wmark_q <= '0;
    end else begin
      wmark_q <= wmark_d;
    end
  end

  assign wmark = wmark_q;
`endif

`ifndef SYNTHESIS
  localparam logic [IF_W-1:0] IF_MAX = IF_W'(LAT + DEPTH);

  // Cleared only when deliberately driving a non-compliant upstream.
  bit proto_chk_en = 1'b1;

  a_y_without_x: assert property (@(posedge clk) disable iff (!rst_b || !proto_chk_en)
    y_dv |-> (inflight_q != '0));

  a_x_without_credit: assert property (@(posedge clk) disable iff (!rst_b || !proto_chk_en)
    x_dv |-> x_ok);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_b || !proto_chk_en)
    !ovf_set);

  a_inflight_range: assert property (@(posedge clk) disable iff (!rst_b)
    inflight_q <= IF_MAX);

  a_m_stable: assert property (@(posedge clk) disable iff (!rst_b)
    (m_valid && !m_ready) |=> (m_valid && $stable(m_data)));
`endif

endmodule

// File: tb/tb_quadra_ybuf.sv
// Scoreboard bench for quadra_ybuf: a LAT-deep upstream model feeds y/y_dv, a negedge monitor
// checks every handshake and the level/ovf/x_ok outputs against a small occupancy model.
module tb_quadra_ybuf;
  import quadra_ybuf_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned LAT   = QUADRA_LAT;
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_b = 1'b0;
  logic             x_dv = 1'b0;
  logic             x_ok;
  y_t               y = '0;
  logic             y_dv = 1'b0;
  y_t               m_data;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [LVL_W-1:0] level;
  logic             ovf;
  logic             ovf_clr = 1'b0;
`ifdef QUADRA_YBUF_WMARK_EN
  logic [LVL_W-1:0] wmark;
`endif

  always #5 clk = ~clk;

  quadra_ybuf #(
    .DEPTH (DEPTH),
    .LAT   (LAT)
  ) dut (
    .clk     (clk),
    .rst_b   (rst_b),
    .x_dv    (x_dv),
    .x_ok    (x_ok),
    .y       (y),
    .y_dv    (y_dv),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .level   (level),
`ifdef QUADRA_YBUF_WMARK_EN
    .wmark   (wmark),
`endif
    .ovf     (ovf),
    .ovf_clr (ovf_clr)
  );

  int   n_chk = 0;
  int   n_fail = 0;
  y_t   sb_q[$];
  int   n_rx = 0;
  int   n_tx = 0;
  int   xok_drops = 0;

  // Upstream pipeline model and stimulus controls
  logic pv [LAT];
  y_t   pd [LAT];
  logic gen_en = 1'b0, obey = 1'b1, rdy = 1'b0, force_y = 1'b0, send_one = 1'b0;
  logic clr = 1'b0, mon_en = 1'b0;
  y_t   force_val = '0, send_val = '0, x_cur = '0, seq = 24'h100000;

  // Occupancy model and the effects pending from the cycle in progress
  int   mlevel = 0, minfl = 0;
  logic movf = 1'b0;
  logic ppush = 1'b0, ppop = 1'b0, pset = 1'b0, pclr = 1'b0, px = 1'b0, py = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    mlevel = 0; minfl = 0; movf = 1'b0;
    ppush = 1'b0; ppop = 1'b0; pset = 1'b0; pclr = 1'b0; px = 1'b0; py = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      pv[i] = 1'b0;
      pd[i] = '0;
    end
    sb_q.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (ppush) mlevel++;
    if (ppop) mlevel--;
    if (pset) movf = 1'b1;
    else if (pclr) movf = 1'b0;
    if (px && !py) minfl++;
    else if (py && !px && minfl > 0) minfl--;
    for (int i = LAT - 1; i > 0; i--) begin
      pv[i] = pv[i-1];
      pd[i] = pd[i-1];
    end
    pv[0] = x_dv;
    pd[0] = x_cur;
    ovf_clr = clr;
    clr     = 1'b0;
    m_ready = rdy;
    if (force_y) begin
      y_dv    = 1'b1;
      y       = force_val;
      force_y = 1'b0;
    end else begin
      y_dv = pv[LAT-1];
      y    = pd[LAT-1];
    end
    x_dv = 1'b0;
    if (send_one) begin
      x_dv     = 1'b1;
      x_cur    = send_val;
      send_one = 1'b0;
    end else if (gen_en && (x_ok || !obey)) begin
      x_dv  = 1'b1;
      x_cur = seq;
      seq   = seq + 24'd1;
    end
    if (x_dv) n_tx++;
    if (gen_en && !x_ok) xok_drops++;
    ppop  = (mlevel != 0) && m_ready;
    ppush = y_dv && ((mlevel < DEPTH) || ppop);
    pset  = y_dv && (mlevel == DEPTH) && !ppop;
    pclr  = ovf_clr;
    px    = x_dv;
    py    = y_dv;
    if (ppush) sb_q.push_back(y);
  endtask

  always @(negedge clk) begin
    if (rst_b && mon_en) begin
      check("mon_level", 32'(level), 32'(mlevel));
      check("mon_m_valid", 32'(m_valid), 32'(mlevel != 0));
      check("mon_ovf", 32'(ovf), 32'(movf));
      check("mon_x_ok", 32'(x_ok), 32'((mlevel + minfl) < DEPTH));
      if (m_valid && m_ready) begin
        if (sb_q.size() == 0) begin
          check("mon_unexpected_word", 32'(m_valid), 32'd0);
        end else begin
          check("mon_m_data", 32'(m_data), 32'(sb_q.pop_front()));
          n_rx++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required $finish before it");
    $fatal(1, "watchdog");
  end

  initial begin
    int tx0, rx0;
    model_clear();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_level", 32'(level), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_x_ok", 32'(x_ok), 32'd1);
`ifdef QUADRA_YBUF_WMARK_EN
    check("rst_wmark", 32'(wmark), 32'd0);
`endif
    @(negedge clk);
    rst_b  = 1'b1;
    mon_en = 1'b1;

    // Single sample: m_valid the cycle after y_dv, then pop
    send_val = 24'h00ABCD;
    send_one = 1'b1;
    repeat (LAT + 1) step();
    check("t1_y_dv", 32'(y_dv), 32'd1);
    step();
    check("t1_m_valid", 32'(m_valid), 32'd1);
    check("t1_m_data", 32'(m_data), 32'h00ABCD);
    check("t1_level", 32'(level), 32'd1);
    rdy = 1'b1;
    step();
    rdy = 1'b0;
    step();
    check("t1_level_after", 32'(level), 32'd0);
    check("t1_m_valid_after", 32'(m_valid), 32'd0);

    // Sustained streaming with m_ready held high
    tx0 = n_tx; rx0 = n_rx; xok_drops = 0;
    gen_en = 1'b1; rdy = 1'b1;
    for (int c = 0; c < 400 && (n_tx - tx0) < 100; c++) step();
    gen_en = 1'b0;
    repeat (LAT + 4) step();
    check("sus_rx_count", 32'(n_rx - rx0), 32'd100);
    check("sus_x_ok_drops", 32'(xok_drops), 32'd0);
    check("sus_ovf", 32'(ovf), 32'd0);
    check("sus_sb_empty", 32'(sb_q.size()), 32'd0);

    // Backpressure: compliant upstream stops at DEPTH words
    tx0 = n_tx;
    rdy = 1'b0; gen_en = 1'b1;
    repeat (20) step();
    gen_en = 1'b0;
    check("bp_sent", 32'(n_tx - tx0), 32'(DEPTH));
    check("bp_level", 32'(level), 32'(DEPTH));
    check("bp_x_ok", 32'(x_ok), 32'd0);
    check("bp_ovf", 32'(ovf), 32'd0);
`ifdef QUADRA_YBUF_WMARK_EN
    check("bp_wmark", 32'(wmark), 32'(DEPTH));
`endif

    // Deliberate misuse: results pushed into a full FIFO with nothing in flight
    dut.proto_chk_en = 1'b0;
    force_val = 24'hDEAD01; force_y = 1'b1;
    step();
    step();
    check("ovf_set", 32'(ovf), 32'd1);
    check("ovf_level", 32'(level), 32'(DEPTH));
    force_val = 24'hDEAD02; force_y = 1'b1; rdy = 1'b1;
    step();
    rdy = 1'b0;
    step();
    check("full_pushpop_level", 32'(level), 32'(DEPTH));
    check("full_pushpop_ovf_sticky", 32'(ovf), 32'd1);
    clr = 1'b1;
    step();
    step();
    check("ovf_clr", 32'(ovf), 32'd0);
    force_val = 24'hDEAD03; force_y = 1'b1; clr = 1'b1;
    step();
    step();
    check("ovf_set_wins", 32'(ovf), 32'd1);
    dut.proto_chk_en = 1'b1;
    rdy = 1'b1;
    repeat (DEPTH + 4) step();
    clr = 1'b1;
    step();
    step();
    check("drain_sb_empty", 32'(sb_q.size()), 32'd0);
    check("drain_level", 32'(level), 32'd0);
    check("drain_ovf", 32'(ovf), 32'd0);

    // Asynchronous reset mid-stream with level=5, inflight=2
    tx0 = n_tx;
    rdy = 1'b0; gen_en = 1'b1;
    for (int c = 0; c < 20 && (n_tx - tx0) < 7; c++) step();
    gen_en = 1'b0;
    for (int c = 0; c < 20 && mlevel < 5; c++) step();
    check("pre_rst_level", 32'(level), 32'd5);
    check("pre_rst_inflight_model", 32'(minfl), 32'd2);
    check("pre_rst_x_ok", 32'(x_ok), 32'd1);
    #2;
    rst_b = 1'b0;
    x_dv  = 1'b0;
    y_dv  = 1'b0;
    model_clear();
    #1;
    check("arst_level", 32'(level), 32'd0);
    check("arst_m_valid", 32'(m_valid), 32'd0);
    check("arst_ovf", 32'(ovf), 32'd0);
`ifdef QUADRA_YBUF_WMARK_EN
    check("arst_wmark", 32'(wmark), 32'd0);
`endif
    @(posedge clk);
    #3;
    rst_b = 1'b1;
    step();
    step();
    check("post_rst_x_ok", 32'(x_ok), 32'd1);
    check("post_rst_level", 32'(level), 32'd0);
    check("final_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
